// File: rtl/chan_ser_pkg.sv
// Shared types and limits for the channel serializer.
// Optional end-of-frame marker is enabled with CHAN_SERIALIZER_LAST_EN.
package chan_ser_pkg;

  localparam int unsigned NUM_CH_MAX = 8;
  localparam int unsigned NUM_CH_MIN = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/chan_ser_cnt.sv
// Channel-index counter: advances on each output transfer, wraps at NUM_CH-1,
// and clears synchronously while en is low.
module chan_ser_cnt
  import chan_ser_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      adv,
  output logic [$clog2(NUM_CH)-1:0] cnt,
  output logic [$clog2(NUM_CH)-1:0] cnt_nxt_c,
  output logic                      at_last_c
);

  localparam int unsigned SW = $clog2(NUM_CH);
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

  assign at_last_c = (cnt == LAST);

  always_comb begin
    cnt_nxt_c = cnt;
    if (!en) begin
      cnt_nxt_c = '0;
    end else if (adv) begin
      cnt_nxt_c = at_last_c ? '0 : cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/chan_serializer.sv
// Parallel-to-serial channel serializer: captures NUM_CH words and emits them
// one per output transfer. Define CHAN_SERIALIZER_LAST_EN to add out_last.
module chan_serializer
  import chan_ser_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DW     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_CH*DW-1:0]      in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DW-1:0]             out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_sel,
  output logic                      sel_load
`ifdef CHAN_SERIALIZER_LAST_EN
  ,
  output logic                      out_last
`endif
);

  localparam int unsigned SW = $clog2(NUM_CH);
  localparam int unsigned HW = NUM_CH * DW;

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || DW < 1) begin : g_param_check
    $error("chan_serializer: NUM_CH must be 2..8 and DW at least 1");
  end

  state_t          state;
  state_t          state_d;
  logic [HW-1:0]   holding;
  logic [HW-1:0]   holding_d;
  logic [DW-1:0]   out_data_d;
  logic            out_valid_d;
  logic [SW-1:0]   cnt;
  logic [SW-1:0]   cnt_nxt;
  logic            at_last;
  logic            in_xfer;
  logic            out_xfer;

  // Ready is gated by the registered enable so it is low throughout reset;
  // the out_ready term lets the next frame load on the last word's transfer.
  assign in_ready = en & sel_load &
                    ((state == IDLE) | ((state == SHIFT) & at_last & out_ready));
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_sel  = cnt;

  chan_ser_cnt #(
    .NUM_CH (NUM_CH)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .adv       (out_xfer),
    .cnt       (cnt),
    .cnt_nxt_c (cnt_nxt),
    .at_last_c (at_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_xfer) state_d = SHIFT;
        SHIFT:   if (out_xfer && at_last && !in_xfer) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values; everything holds unless a transfer occurs
  always_comb begin
    holding_d   = holding;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    if (!en) begin
      holding_d   = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (in_xfer) begin
      holding_d   = in_data;
      out_valid_d = 1'b1;
      out_data_d  = in_data[DW-1:0];
    end else if (out_xfer) begin
      if (at_last) begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end else begin
        out_data_d = DW'(holding >> (DW * 32'(cnt_nxt)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holding   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel_load  <= 1'b0;
    end else begin
      holding   <= holding_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      sel_load  <= en;
    end
  end

`ifdef CHAN_SERIALIZER_LAST_EN
  logic out_last_d;

  assign out_last_d = out_valid_d & (cnt_nxt == SW'(NUM_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last <= 1'b0;
    end else begin
      out_last <= out_last_d;
    end
  end
`endif

endmodule

// File: tb/tb_chan_serializer.sv
// Directed bench for chan_serializer: table-driven NUM_CH=4 vectors plus
// hand sequences for NUM_CH=2, async reset and (optionally) out_last.
module tb_chan_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NUM_CH=2, DW=1 instance
  logic       en2, iv2, ir2, ov2, or2, sl2;
  logic [1:0] id2;
  logic [0:0] od2, os2;
  // NUM_CH=4, DW=2 instance
  logic       en4, iv4, ir4, ov4, or4, sl4;
  logic [7:0] id4;
  logic [1:0] od4, os4;
`ifdef CHAN_SERIALIZER_LAST_EN
  logic       lst2, lst4, lst3;
  logic       en3, iv3, ir3, ov3, or3, sl3;
  logic [5:0] id3;
  logic [1:0] od3, os3;
`endif

  chan_serializer #(.NUM_CH(2), .DW(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .in_data(id2), .in_valid(iv2),
    .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(or2),
    .out_sel(os2), .sel_load(sl2)
`ifdef CHAN_SERIALIZER_LAST_EN
    , .out_last(lst2)
`endif
  );

  chan_serializer #(.NUM_CH(4), .DW(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .in_data(id4), .in_valid(iv4),
    .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(or4),
    .out_sel(os4), .sel_load(sl4)
`ifdef CHAN_SERIALIZER_LAST_EN
    , .out_last(lst4)
`endif
  );

`ifdef CHAN_SERIALIZER_LAST_EN
  chan_serializer #(.NUM_CH(3), .DW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .in_data(id3), .in_valid(iv3),
    .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(or3),
    .out_sel(os3), .sel_load(sl3), .out_last(lst3)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ov;
    logic [1:0] e_sel;
    logic [1:0] e_d;
    logic       e_ir;
    logic       e_sl;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  initial begin
    // en, in_valid, in_data, out_ready | out_valid, out_sel, out_data, in_ready, sel_load
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hE4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 8'h1B, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'h1B, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h1B, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h1B, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'hE4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 8'h1B, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 8'h1B, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 8'h1B, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 8'h1B, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b1};

    rst_n = 1'b0;
    en2 = 1'b0; iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    en4 = 1'b0; iv4 = 1'b0; id4 = '0; or4 = 1'b0;
`ifdef CHAN_SERIALIZER_LAST_EN
    en3 = 1'b0; iv3 = 1'b0; id3 = '0; or3 = 1'b0;
`endif
    #12;
    check("rst out_valid", 32'(ov4), 32'd0);
    check("rst out_sel",   32'(os4), 32'd0);
    check("rst out_data",  32'(od4), 32'd0);
    check("rst in_ready",  32'(ir4), 32'd0);
    check("rst sel_load",  32'(sl4), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // NUM_CH=2 I/Q frame 2'b10 -> 0 then 1
    @(posedge clk); #1;
    en2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b1; id2 = 2'b10; or2 = 1'b1;
    @(negedge clk);
    check("c1 in_ready", 32'(ir2), 32'd1);
    @(posedge clk); #1;
    iv2 = 1'b0;
    @(negedge clk);
    check("c1 w0 valid", 32'(ov2), 32'd1);
    check("c1 w0 sel",   32'(os2), 32'd0);
    check("c1 w0 data",  32'(od2), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("c1 w1 valid", 32'(ov2), 32'd1);
    check("c1 w1 sel",   32'(os2), 32'd1);
    check("c1 w1 data",  32'(od2), 32'd1);
`ifdef CHAN_SERIALIZER_LAST_EN
    check("c1 w1 last",  32'(lst2), 32'd1);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("c1 idle valid", 32'(ov2), 32'd0);
    check("c1 idle ready", 32'(ir2), 32'd1);
    @(posedge clk); #1;

    // NUM_CH=4 streaming, stall, and enable-drop vectors
    for (int i = 0; i < NV; i++) begin
      en4 = vecs[i].en; iv4 = vecs[i].iv; id4 = vecs[i].d; or4 = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), 32'(ov4), 32'(vecs[i].e_ov));
      check($sformatf("v%0d out_sel", i),   32'(os4), 32'(vecs[i].e_sel));
      check($sformatf("v%0d out_data", i),  32'(od4), 32'(vecs[i].e_d));
      check($sformatf("v%0d in_ready", i),  32'(ir4), 32'(vecs[i].e_ir));
      check($sformatf("v%0d sel_load", i),  32'(sl4), 32'(vecs[i].e_sl));
      @(posedge clk); #1;
    end

    // Async reset mid-frame: outputs clear without a clock edge
    check("pre-rst sel",  32'(os4), 32'd1);
    check("pre-rst data", 32'(od4), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", 32'(ov4), 32'd0);
    check("arst out_sel",   32'(os4), 32'd0);
    check("arst out_data",  32'(od4), 32'd0);
    check("arst sel_load",  32'(sl4), 32'd0);
    check("arst in_ready",  32'(ir4), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b1; id4 = 8'hE4; or4 = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 32'(ir4), 32'd1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(negedge clk);
    check("post-rst valid", 32'(ov4), 32'd1);
    check("post-rst sel",   32'(os4), 32'd0);
    check("post-rst data",  32'(od4), 32'd0);

`ifdef CHAN_SERIALIZER_LAST_EN
    // NUM_CH=3: out_last only on the out_sel=2 word
    @(posedge clk); #1;
    en3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b1; id3 = 6'b10_01_00; or3 = 1'b1;
    @(negedge clk);
    check("c6 in_ready", 32'(ir3), 32'd1);
    check("c6 idle last", 32'(lst3), 32'd0);
    @(posedge clk); #1;
    iv3 = 1'b0;
    @(negedge clk);
    check("c6 w0 sel",  32'(os3), 32'd0);
    check("c6 w0 last", 32'(lst3), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("c6 w1 sel",  32'(os3), 32'd1);
    check("c6 w1 last", 32'(lst3), 32'd0);
    @(posedge clk); #1;
    or3 = 1'b0;
    @(negedge clk);
    check("c6 w2 sel",  32'(os3), 32'd2);
    check("c6 w2 data", 32'(od3), 32'd2);
    check("c6 w2 last", 32'(lst3), 32'd1);
    @(posedge clk); #1;
    or3 = 1'b1;
    @(negedge clk);
    check("c6 w2 hold last", 32'(lst3), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("c6 done valid", 32'(ov3), 32'd0);
    check("c6 done last",  32'(lst3), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
